// File: rtl/ram_readback_checker_pkg.sv
// rtl/ram_readback_checker_pkg.sv - FSM encoding and default widths shared by the readback checker
package ram_readback_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } chk_state_t;

   localparam int DEF_AW     = 8;
   localparam int DEF_RD_LAT = 2;

endpackage

// File: rtl/ram_readback_checker_rd_tag_pipe.sv
// rtl/ram_readback_checker_rd_tag_pipe.sv - {valid, addr} delay line that tracks reads in flight
module rd_tag_pipe
   import ram_readback_checker_pkg::*;
#(
   parameter int AW    = DEF_AW,
   parameter int DEPTH = DEF_RD_LAT
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          i_valid,
   input  logic [AW-1:0] i_addr,
   output logic          o_valid,
   output logic [AW-1:0] o_addr,
   output logic          o_any_valid
);

   logic [DEPTH-1:0] r_valid;
   logic [AW-1:0]    r_addr [DEPTH];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_addr[i] <= '0;
         end
      end else begin
         r_valid[0] <= i_valid;
         r_addr[0]  <= i_addr;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_addr[i]  <= r_addr[i-1];
         end
      end
   end

   assign o_valid     = r_valid[DEPTH-1];
   assign o_addr      = r_addr[DEPTH-1];
   assign o_any_valid = |r_valid;

endmodule

// File: rtl/ram_readback_checker.sv
// rtl/ram_readback_checker.sv - sweeps a RAM address range and checks data == addr ^ XOR_MASK
module ram_readback_checker
   import ram_readback_checker_pkg::*;
#(
   parameter int            AW       = DEF_AW,
   parameter int            START_A  = 0,
   parameter int            END_A    = 255,
   parameter logic [AW-1:0] XOR_MASK = '0,
   parameter int            RD_LAT   = DEF_RD_LAT,
   parameter int            ERR_W    = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   output logic [AW-1:0]    mem_address,
   output logic [AW-1:0]    mem_data,
   output logic             mem_wren,
   input  logic [AW-1:0]    mem_q,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [AW-1:0]    first_err_addr,
   output logic [AW-1:0]    first_err_data,
   output logic [AW-1:0]    ram_out
);

   localparam logic [AW-1:0] LP_START = AW'(START_A);
   localparam logic [AW-1:0] LP_END   = AW'(END_A);

   chk_state_t       r_state;
   chk_state_t       w_next;
   logic             r_armed;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [ERR_W-1:0] r_err_count;
   logic [AW-1:0]    r_first_addr;
   logic [AW-1:0]    r_first_data;
   logic [AW-1:0]    r_ram_out;
   logic [AW-1:0]    r_addr;

   logic             w_accept;
   logic             w_push_valid;
   logic [AW-1:0]    w_push_addr;
   logic             w_pipe_valid;
   logic [AW-1:0]    w_pipe_addr;
   logic             w_pipe_any;
   logic             w_mismatch;

   // r_armed masks a start that coincides with reset release; r_done masks one during the done pulse
   assign w_accept   = (r_state == ST_IDLE) && start && r_armed && !r_done;
   assign w_mismatch = w_pipe_valid && (mem_q != (w_pipe_addr ^ XOR_MASK));

   rd_tag_pipe #(
      .AW    (AW),
      .DEPTH (RD_LAT)
   ) u_tag_pipe (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_valid     (w_push_valid),
      .i_addr      (w_push_addr),
      .o_valid     (w_pipe_valid),
      .o_addr      (w_pipe_addr),
      .o_any_valid (w_pipe_any)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // A tag is pushed on the same edge that moves the address, so it emerges exactly RD_LAT later
   always_comb begin
      w_next       = r_state;
      w_push_valid = 1'b0;
      w_push_addr  = r_addr;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next       = ST_ISSUE;
               w_push_valid = 1'b1;
               w_push_addr  = LP_START;
            end
         end
         ST_ISSUE: begin
            if (r_addr == LP_END) begin
               w_next = ST_DRAIN;
            end else begin
               w_push_valid = 1'b1;
               w_push_addr  = r_addr + AW'(1);
            end
         end
         ST_DRAIN: begin
            if (!w_pipe_any) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_armed      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_count  <= '0;
         r_first_addr <= '0;
         r_first_data <= '0;
         r_ram_out    <= '0;
         r_addr       <= LP_START;
      end else begin
         r_armed <= 1'b1;
         r_done  <= 1'b0;
         if (w_push_valid) begin
            r_addr <= w_push_addr;
         end
         if (w_accept) begin
            r_busy       <= 1'b1;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_first_addr <= '0;
            r_first_data <= '0;
         end
         if (r_state == ST_DONE) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (r_err_count == '0);
         end
         if (w_pipe_valid) begin
            r_ram_out <= mem_q;
            if (w_mismatch) begin
               if (r_err_count != '1) begin
                  r_err_count <= r_err_count + ERR_W'(1);
               end
               if (r_err_count == '0) begin
                  r_first_addr <= w_pipe_addr;
                  r_first_data <= mem_q;
               end
            end
         end
      end
   end

   assign mem_address    = r_addr;
   assign mem_data       = '0;
   assign mem_wren       = 1'b0;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_count      = r_err_count;
   assign first_err_addr = r_first_addr;
   assign first_err_data = r_first_data;
   assign ram_out        = r_ram_out;

endmodule

// File: tb/tb_ram_readback_checker.sv
// tb/tb_ram_readback_checker.sv - directed bench: full sweeps, corruptions, single-address sweep, reset abort
module tb_ram_readback_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start0 = 1'b0;
   logic        start1 = 1'b0;
   int          cyc = 0;
   int          n_err = 0;
   int          n_chk = 0;
   logic        wren_seen = 1'b0;

   logic [7:0]  mem0 [256];
   logic [7:0]  mem1 [256];

   logic [7:0]  addr0, data0, q0, fea0, fed0, ro0;
   logic        wren0, busy0, done0, pass0;
   logic [15:0] err0;
   logic [7:0]  addr1, data1, q1, fea1, fed1, ro1;
   logic        wren1, busy1, done1, pass1;
   logic [15:0] err1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Registered-read RAM: address update on edge k, data sampled on edge k+2
   always @(posedge clk) q0 <= mem0[addr0];
   always @(posedge clk) q1 <= mem1[addr1];

   always @(posedge clk) begin
      if (wren0 || wren1 || (|data0) || (|data1)) wren_seen <= 1'b1;
   end

   ram_readback_checker u_dut0 (
      .clock          (clk),
      .reset_n        (rst_n),
      .start          (start0),
      .mem_address    (addr0),
      .mem_data       (data0),
      .mem_wren       (wren0),
      .mem_q          (q0),
      .busy           (busy0),
      .done           (done0),
      .pass           (pass0),
      .err_count      (err0),
      .first_err_addr (fea0),
      .first_err_data (fed0),
      .ram_out        (ro0)
   );

   ram_readback_checker #(
      .START_A  (5),
      .END_A    (5),
      .XOR_MASK (8'h3C)
   ) u_dut1 (
      .clock          (clk),
      .reset_n        (rst_n),
      .start          (start1),
      .mem_address    (addr1),
      .mem_data       (data1),
      .mem_wren       (wren1),
      .mem_q          (q1),
      .busy           (busy1),
      .done           (done1),
      .pass           (pass1),
      .err_count      (err1),
      .first_err_addr (fea1),
      .first_err_data (fed1),
      .ram_out        (ro1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run0(input int extra_at, output int lat, output int err_at_start, output int busy_at_start);
      int t0;
      lat = -1;
      @(posedge clk); #1;
      start0 = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start0 = 1'b0;
      err_at_start  = int'(err0);
      busy_at_start = int'(busy0);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         start0 = (k == extra_at);
         if (done0) begin
            lat = cyc - t0;
            break;
         end
      end
      start0 = 1'b0;
      @(negedge clk);
      chk("done0_one_cycle", done0, 1'b0);
   endtask

   task automatic run1(output int lat);
      int t0;
      lat = -1;
      @(posedge clk); #1;
      start1 = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done1) begin
            lat = cyc - t0;
            break;
         end
      end
   endtask

   initial begin
      int lat, eas, bas;
      logic seen_done, seen_busy;

      for (int a = 0; a < 256; a++) begin
         mem0[a] = 8'(a);
         mem1[a] = 8'(a);
      end
      mem1[5] = 8'h05 ^ 8'h3C;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy0, 1'b0);
      chk("rst_done", done0, 1'b0);
      chk("rst_pass", pass0, 1'b0);
      chk("rst_err", err0, 16'h0);
      chk("rst_first_addr", fea0, 8'h00);
      chk("rst_ram_out", ro0, 8'h00);
      chk("rst_addr0_start", addr0, 8'h00);
      chk("rst_addr1_start", addr1, 8'h05);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Scenario 1: clean full sweep
      run0(-1, lat, eas, bas);
      chk("s1_latency", lat, 32'd260);
      chk("s1_pass", pass0, 1'b1);
      chk("s1_err", err0, 16'h0);
      chk("s1_ram_out_last", ro0, 8'hFF);
      chk("s1_addr_no_wrap", addr0, 8'hFF);
      chk("s1_busy_low", busy0, 1'b0);
      repeat (5) @(negedge clk);
      chk("s1_pass_held", pass0, 1'b1);

      // Scenario 2: single corruption
      mem0[8'h10] = 8'hFF;
      run0(-1, lat, eas, bas);
      chk("s2_latency", lat, 32'd260);
      chk("s2_err", err0, 16'd1);
      chk("s2_first_addr", fea0, 8'h10);
      chk("s2_first_data", fed0, 8'hFF);
      chk("s2_pass", pass0, 1'b0);
      mem0[8'h10] = 8'h10;

      // Scenario 3: two corruptions, first one captured
      mem0[8'h20] = 8'hAA;
      mem0[8'h80] = 8'h55;
      run0(-1, lat, eas, bas);
      chk("s3_err", err0, 16'd2);
      chk("s3_first_addr", fea0, 8'h20);
      chk("s3_first_data", fed0, 8'hAA);
      chk("s3_pass", pass0, 1'b0);
      mem0[8'h20] = 8'h20;
      mem0[8'h80] = 8'h80;

      // Scenario 6: extra start while busy is ignored
      run0(50, lat, eas, bas);
      chk("s6_err_cleared_at_start", eas, 32'd0);
      chk("s6_busy_at_start", bas, 32'd1);
      chk("s6_latency", lat, 32'd260);
      chk("s6_pass", pass0, 1'b1);
      chk("s6_err", err0, 16'h0);
      chk("s6_first_addr_cleared", fea0, 8'h00);

      // Scenario 4: single-address sweep with a nonzero mask
      run1(lat);
      chk("s4_latency", lat, 32'd5);
      chk("s4_pass", pass1, 1'b1);
      chk("s4_err", err1, 16'h0);
      chk("s4_ram_out", ro1, 8'h39);
      chk("s4_addr", addr1, 8'h05);
      mem1[5] = 8'h00;
      run1(lat);
      chk("s4b_err", err1, 16'd1);
      chk("s4b_first_addr", fea1, 8'h05);
      chk("s4b_first_data", fed1, 8'h00);
      chk("s4b_pass", pass1, 1'b0);

      // Scenario 5: reset mid-sweep, start coinciding with release
      @(posedge clk); #1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("s5_busy", busy0, 1'b0);
      chk("s5_addr", addr0, 8'h00);
      chk("s5_ram_out", ro0, 8'h00);
      chk("s5_pass", pass0, 1'b0);
      chk("s5_pass1", pass1, 1'b0);
      chk("s5_err1", err1, 16'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      seen_done = 1'b0;
      seen_busy = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done0) seen_done = 1'b1;
         if (busy0) seen_busy = 1'b1;
      end
      chk("s5_no_done", seen_done, 1'b0);
      chk("s5_start_at_release_ignored", seen_busy, 1'b0);
      run0(-1, lat, eas, bas);
      chk("s5_clean_latency", lat, 32'd260);
      chk("s5_clean_pass", pass0, 1'b1);
      chk("s5_clean_err", err0, 16'h0);

      chk("never_write", wren_seen, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
